full_adder: RTL and testbench

- Registered WIDTH-bit ripple-carry adder/subtractor datapath.
- Built structurally from per-bit 1-bit full-adder cells and 2:1 mux cells. Each bit's mux picks B or ~B under `sub`.
- Subtract is two's complement: ~B plus carry-in = 1.
- Sits in the ALU path of the pipelined CPU. Produces sum plus ARM-style flags (C, V, N, Z) one cycle after operands are presented.

---
 rtl/full_adder.sv | 111 +++++++++++
 tb/tb_full_adder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Purpose  : Registered WIDTH-bit ripple-carry adder/subtractor with C/V/N/Z
//            flags, built from per-bit full-adder and 2:1 mux cells.
// Revision : 1.0 - initial release
// ============================================================================

module full_adder_mux2_cell (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

module full_adder_fa_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    logic w_p;

    assign w_p   = a ^ b;
    assign s     = w_p ^ c_in;
    assign c_out = (a & b) | (c_in & w_p);
endmodule

module full_adder #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);
    logic [WIDTH-1:0] w_b_n;
    logic [WIDTH-1:0] w_sel_b;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_c_in;
    logic             w_overflow;
    logic             w_zero;

    logic [WIDTH-1:0] r_sum;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_negative;
    logic             r_zero;

    assign w_b_n = ~B;

    // Subtract injects the +1 of the two's complement through bit 0's carry-in.
    assign w_c_in = {w_c[WIDTH-2:0], sub};

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            full_adder_mux2_cell u_mux (
                .d0  (B[i]),
                .d1  (w_b_n[i]),
                .sel (sub),
                .y   (w_sel_b[i])
            );

            full_adder_fa_cell u_fa (
                .a     (A[i]),
                .b     (w_sel_b[i]),
                .c_in  (w_c_in[i]),
                .s     (w_s[i]),
                .c_out (w_c[i])
            );
        end
    endgenerate

    assign w_overflow = w_c[WIDTH-2] ^ w_c[WIDTH-1];
    assign w_zero     = ~|w_s;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_negative  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (en) begin
            r_sum       <= w_s;
            r_carry_out <= w_c[WIDTH-1];
            r_overflow  <= w_overflow;
            r_negative  <= w_s[WIDTH-1];
            r_zero      <= w_zero;
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign negative  = r_negative;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_full_adder
// Purpose  : Scoreboard bench for full_adder; packed result is
//            {sum, C, V, N, Z}, compared one cycle after each enabled op.
// Revision : 1.0 - initial release
// ============================================================================

module tb_full_adder;

    localparam int c_W = 64;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           en;
    logic [c_W-1:0] A;
    logic [c_W-1:0] B;
    logic           sub;
    logic [c_W-1:0] sum;
    logic           carry_out;
    logic           overflow;
    logic           negative;
    logic           zero;

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [c_W+3:0] sb[$];
    logic [c_W+3:0] r_exp;
    logic [c_W+3:0] w_obs;

    full_adder #(.WIDTH(c_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .negative  (negative),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    assign w_obs = {sum, carry_out, overflow, negative, zero};

    // Reference model: wide arithmetic plus sign-rule overflow.
    function automatic logic [c_W+3:0] model(input logic [c_W-1:0] a,
                                             input logic [c_W-1:0] b,
                                             input logic s);
        logic [c_W:0]   t;
        logic [c_W-1:0] r;
        logic           v;
        if (s) t = {1'b0, a} + {1'b0, ~b} + {{c_W{1'b0}}, 1'b1};
        else   t = {1'b0, a} + {1'b0, b};
        r = t[c_W-1:0];
        if (s) v = (a[c_W-1] != b[c_W-1]) && (r[c_W-1] != a[c_W-1]);
        else   v = (a[c_W-1] == b[c_W-1]) && (r[c_W-1] != a[c_W-1]);
        return {r, t[c_W], v, r[c_W-1], (r == '0)};
    endfunction

    // Inputs change 1 ns after a rising edge; outputs are read 1 ns after the next.
    task automatic drive(input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                         input logic s, input logic e);
        A = a; B = b; sub = s; en = e;
        if (e && reset_n) sb.push_back(model(a, b, s));
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp();
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries, expected at least 1");
            r_exp = 'x;
        end else begin
            r_exp = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive('1, '1, 1'b0, 1'b1);
            n_tests++;
            if (w_obs !== '0) begin
                n_fail++;
                $display("FAIL reset_%0d: got %h, expected %h", i, w_obs, {(c_W+4){1'b0}});
            end
        end
        reset_n = 1'b1;
        drive('1, '1, 1'b0, 1'b1);
        pop_exp();
        n_tests++;
        if (w_obs !== r_exp || r_exp !== {{(c_W-1){1'b1}}, 1'b0, 4'b1010}) begin
            n_fail++;
            $display("FAIL reset_release: got %h, expected %h", w_obs, r_exp);
        end
    endtask

    task automatic test_add();
        drive(64'd5, 64'd3, 1'b0, 1'b1);
        pop_exp();
        n_tests++;
        if (w_obs !== {64'd8, 4'b0000}) begin
            n_fail++;
            $display("FAIL add_5_3: got %h, expected %h", w_obs, {64'd8, 4'b0000});
        end
    endtask

    task automatic test_sub_borrow();
        drive(64'd3, 64'd5, 1'b1, 1'b1);
        pop_exp();
        n_tests++;
        if (w_obs !== {64'hFFFF_FFFF_FFFF_FFFE, 4'b0010}) begin
            n_fail++;
            $display("FAIL sub_borrow: got %h, expected %h", w_obs,
                     {64'hFFFF_FFFF_FFFF_FFFE, 4'b0010});
        end
    endtask

    task automatic test_sub_equal();
        drive(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1);
        pop_exp();
        n_tests++;
        if (w_obs !== {64'd0, 4'b1001}) begin
            n_fail++;
            $display("FAIL sub_equal: got %h, expected %h", w_obs, {64'd0, 4'b1001});
        end
    endtask

    task automatic test_overflow();
        logic [c_W+3:0] req [3];
        req[0] = {64'h8000_0000_0000_0000, 4'b0110};
        req[1] = {64'h0000_0000_0000_0000, 4'b1001};
        req[2] = {64'h7FFF_FFFF_FFFF_FFFF, 4'b1100};
        drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
        drive(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            pop_exp();
            n_tests++;
            if (r_exp !== req[i]) begin
                n_fail++;
                $display("FAIL overflow_model_%0d: got %h, expected %h", i, r_exp, req[i]);
            end
        end
        // Back-to-back results land one per cycle; re-run and check each live.
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
                1: drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
                default: drive(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);
            endcase
            pop_exp();
            n_tests++;
            if (w_obs !== req[i]) begin
                n_fail++;
                $display("FAIL overflow_%0d: got %h, expected %h", i, w_obs, req[i]);
            end
        end
    endtask

    task automatic test_enable_hold();
        drive(64'd5, 64'd3, 1'b0, 1'b1);
        pop_exp();
        for (int i = 0; i < 3; i++) begin
            drive(64'd1, 64'd1, 1'b0, 1'b0);
            n_tests++;
            if (w_obs !== {64'd8, 4'b0000}) begin
                n_fail++;
                $display("FAIL hold_%0d: got %h, expected %h", i, w_obs, {64'd8, 4'b0000});
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive(64'd100 + 64'(i), 64'd7 * 64'(i), i[0], 1'b1);
            pop_exp();
            n_tests++;
            if (w_obs !== r_exp) begin
                n_fail++;
                $display("FAIL b2b_%0d: got %h, expected %h", i, w_obs, r_exp);
            end
        end
    endtask

    task automatic test_midstream_reset();
        drive(64'd9, 64'd9, 1'b0, 1'b1);
        pop_exp();
        reset_n = 1'b0;
        drive(64'd1, 64'd2, 1'b0, 1'b1);
        n_tests++;
        if (w_obs !== '0) begin
            n_fail++;
            $display("FAIL midstream_reset: got %h, expected %h", w_obs, {(c_W+4){1'b0}});
        end
        reset_n = 1'b1;
        drive(64'd1, 64'd2, 1'b0, 1'b1);
        pop_exp();
        n_tests++;
        if (w_obs !== {64'd3, 4'b0000}) begin
            n_fail++;
            $display("FAIL post_reset_first: got %h, expected %h", w_obs, {64'd3, 4'b0000});
        end
    endtask

    task automatic test_random();
        logic [c_W-1:0] a;
        logic [c_W-1:0] b;
        for (int i = 0; i < 10000; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 16 == 0) b = a;
            drive(a, b, 1'($urandom_range(0, 1)), 1'b1);
            pop_exp();
            n_tests++;
            if (w_obs !== r_exp) begin
                n_fail++;
                $display("FAIL random_%0d: got %h, expected %h", i, w_obs, r_exp);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; A = '0; B = '0; sub = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_sub_borrow();
        test_sub_equal();
        test_overflow();
        test_enable_hold();
        test_back_to_back();
        test_midstream_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
